fetch_stage: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage RV32I pipeline, directly upstream of the decode stage. It owns the architectural fetch PC, issues requests to instruction memory over a valid/ready request and valid-only response interface, and buffers returned words in a 2-entry queue. It drives the IF/ID pipeline register (`PC_pype0`, `PCp4_pype0`, `Instraction_pype`). It honours the pipeline-wide `keep` (hold) and branch/jump redirects, and inserts `addi x0,x0,0` bubbles whenever no fetched instruction is available.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 17 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSN = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [1:0]  IF_QDEPTH    = 2'd2;           // fetch queue / tag queue depth

    // One buffered instruction: where it came from and what it is.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low two bits are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request, valid-only in-order response.
//   A request transfers on a clock edge where req && ready are both high.
//   Once req is high, addr holds until that transfer (a redirect may change it).
//   A response transfers on any edge where rvalid is high; there is no back-pressure.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO with push, pop and clear. Pop of an empty FIFO and
// push into a full FIFO without a simultaneous pop are ignored; clear wins over both.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt == IF_QDEPTH);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage; contents are only meaningful while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the fetch PC, issues credit-limited requests to instruction
// memory, buffers returned words, and loads the IF/ID register (or a bubble).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSN = DEF_NOP_INSN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 keep,
    input  logic                 flush,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        imem,
    output logic [31:0]          PC_pype0,
    output logic [31:0]          PCp4_pype0,
    output logic [31:0]          Instraction_pype,
    output logic                 if_bubble
);

    logic [31:0]  pc_q;
    logic [1:0]   drop_q;

    // Data queue signals
    fetch_entry_t q_head;
    logic [1:0]   q_cnt;
    logic         q_full;
    logic         q_empty;
    logic         q_pop;
    logic         resp_push;

    // In-flight tag queue signals; its occupancy is the outstanding count.
    logic [31:0]  tag_pc;
    logic [1:0]   outst;
    logic         tag_full;
    logic         tag_empty;
    logic         tag_pop;

    logic         accept;
    logic [1:0]   occ;
    logic [1:0]   drop_after_flush;

    // A redirect clears the queue instead of popping it; keep freezes pops.
    assign q_pop   = !flush && !keep && !q_empty;
    assign tag_pop = imem.rvalid && !tag_empty;

    // A response is kept only if nothing remains to be discarded and no redirect
    // is clearing the queue on this same edge.
    assign resp_push = tag_pop && (drop_q == 2'd0) && !flush;

    // Slots claimed after this edge's pop; requests are issued only while one is free,
    // so buffered plus in-flight words never exceed the queue depth.
    assign occ = q_cnt + outst - {1'b0, q_pop};

    // The two FIFO guards are implied by the credit check; they make overrun impossible.
    assign imem.req  = rst && (occ < IF_QDEPTH) && !tag_full && !(q_full && !q_pop);
    assign imem.addr = pc_q;
    assign accept    = imem.req && imem.ready;

    // Requests still in flight once a redirect edge has passed: those already out,
    // plus one accepted now, minus one whose response lands now.
    assign drop_after_flush = outst + {1'b0, accept} - {1'b0, tag_pop};

    fetch_fifo #(.W(64)) u_data_q (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (resp_push),
        .pop   (q_pop),
        .din   ({tag_pc, imem.rdata}),
        .dout  (q_head),
        .cnt   (q_cnt),
        .full  (q_full),
        .empty (q_empty)
    );

    // Tags are never cleared: discarded responses still have to retire their tag
    // so later responses line up with the right pc.
    fetch_fifo #(.W(32)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .push  (accept),
        .pop   (tag_pop),
        .din   (pc_q),
        .dout  (tag_pc),
        .cnt   (outst),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // Fetch PC: jump on redirect, otherwise advance only when a request is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (flush) begin
            pc_q <= word_align(redirect_pc);
        end else if (accept) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    // Count of stale responses to throw away after a redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 2'd0;
        end else if (flush) begin
            drop_q <= drop_after_flush;
        end else if (tag_pop && (drop_q != 2'd0)) begin
            drop_q <= drop_q - 2'd1;
        end
    end

    // IF/ID register: redirect, then hold, then queue head, else a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC_pype0         <= RESET_PC;
            PCp4_pype0       <= RESET_PC + 32'd4;
            Instraction_pype <= NOP_INSN;
            if_bubble        <= 1'b1;
        end else if (flush) begin
            Instraction_pype <= NOP_INSN;
            if_bubble        <= 1'b1;
        end else if (keep) begin
            Instraction_pype <= Instraction_pype;
        end else if (!q_empty) begin
            PC_pype0         <= q_head.pc;
            PCp4_pype0       <= q_head.pc + 32'd4;
            Instraction_pype <= q_head.insn;
            if_bubble        <= 1'b0;
        end else begin
            Instraction_pype <= NOP_INSN;
            if_bubble        <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, keep, redirect, memory stall,
// and reset in the middle of streaming, against a small in-order memory model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk         = 1'b0;
    logic        rst         = 1'b0;
    logic        keep        = 1'b0;
    logic        flush       = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_resp_en = 1'b1;

    logic [31:0] PC_pype0;
    logic [31:0] PCp4_pype0;
    logic [31:0] Instraction_pype;
    logic        if_bubble;

    int checks   = 0;
    int failures = 0;

    fetch_stage_if imem();

    fetch_stage dut (
        .clk              (clk),
        .rst              (rst),
        .keep             (keep),
        .flush            (flush),
        .redirect_pc      (redirect_pc),
        .imem             (imem),
        .PC_pype0         (PC_pype0),
        .PCp4_pype0       (PCp4_pype0),
        .Instraction_pype (Instraction_pype),
        .if_bubble        (if_bubble)
    );

    // Clock and reset block
    always #5 clk = ~clk;

    // Memory contents: word n holds addi x(n+1),x0,n+1 (0x00100093, 0x00200113, ...).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] n1;
        n1 = (a >> 2) + 32'd1;
        return (n1 << 20) | (n1 << 7) | 32'h13;
    endfunction

    // Memory model, evaluated on the falling edge: answer the oldest accepted
    // request (at least one cycle after it was taken), then note a new acceptance.
    logic [31:0] pend_q[$];
    always @(negedge clk) begin
        if (!rst) begin
            pend_q.delete();
            imem.rvalid = 1'b0;
            imem.rdata  = 32'h0;
        end else begin
            imem.rvalid = 1'b0;
            if (mem_resp_en && pend_q.size() > 0) begin
                imem.rvalid = 1'b1;
                imem.rdata  = mem_word(pend_q.pop_front());
            end
            if (imem.req && imem.ready) pend_q.push_back(imem.addr);
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] insn, input logic bub);
        chk({tag, "_pc"},   PC_pype0, pc);
        chk({tag, "_pcp4"}, PCp4_pype0, pc + 32'd4);
        chk({tag, "_insn"}, Instraction_pype, insn);
        chk({tag, "_bub"},  {31'b0, if_bubble}, {31'b0, bub});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'b0, imem.req}, {31'b0, req});
        if (req) chk({tag, "_addr"}, imem.addr, addr);
    endtask

    initial begin
        imem.ready = 1'b1;

        // Reset held for three cycles
        repeat (3) cyc();
        #1;
        chk_ifid("rst", 32'h0, 32'h13, 1'b1);
        chk_req("rst", 1'b0, 32'h0);

        // Release: first request goes out at RESET_PC
        cyc(); rst = 1'b1; #1;
        chk_req("rel", 1'b1, 32'h0);
        chk_ifid("rel", 32'h0, 32'h13, 1'b1);
        cyc(); #1; chk_ifid("fill1", 32'h0, 32'h13, 1'b1);
        cyc(); #1; chk_ifid("fill2", 32'h0, 32'h13, 1'b1);

        // Streaming, one instruction per cycle
        cyc(); #1; chk_ifid("s0", 32'h0, 32'h0010_0093, 1'b0);
        cyc(); #1; chk_ifid("s1", 32'h4, 32'h0020_0113, 1'b0);
        cyc(); #1; chk_ifid("s2", 32'h8, 32'h0030_0193, 1'b0);

        // Keep for three cycles: IF/ID frozen, requests stop once credits run out
        cyc(); keep = 1'b1; #1;
        chk_ifid("k0", 32'hC, 32'h0040_0213, 1'b0); chk_req("k0", 1'b0, 32'h0);
        cyc(); #1;
        chk_ifid("k1", 32'hC, 32'h0040_0213, 1'b0); chk_req("k1", 1'b0, 32'h0);
        cyc(); #1;
        chk_ifid("k2", 32'hC, 32'h0040_0213, 1'b0); chk_req("k2", 1'b0, 32'h0);
        cyc(); keep = 1'b0; #1;
        chk_ifid("k3", 32'hC, 32'h0040_0213, 1'b0); chk_req("k3", 1'b1, 32'h18);
        cyc(); #1; chk_ifid("r0", 32'h10, 32'h0050_0293, 1'b0);
        cyc(); #1; chk_ifid("r1", 32'h14, 32'h0060_0313, 1'b0);
        cyc(); #1; chk_ifid("r2", 32'h18, 32'h0070_0393, 1'b0);
        cyc(); #1; chk_ifid("r3", 32'h1C, 32'h0080_0413, 1'b0);

        // Hold responses back so two requests are in flight, then redirect
        cyc(); mem_resp_en = 1'b0; #1;
        chk_ifid("pre", 32'h20, 32'h0090_0493, 1'b0); chk_req("pre", 1'b1, 32'h2C);
        // Low address bits of the target are ignored
        cyc(); mem_resp_en = 1'b1; flush = 1'b1; redirect_pc = 32'h103; #1;
        chk_ifid("fl", 32'h24, 32'h00A0_0513, 1'b0); chk_req("fl", 1'b0, 32'h0);
        cyc(); flush = 1'b0; redirect_pc = 32'h0; #1;
        chk("f1_insn", Instraction_pype, 32'h13); chk("f1_bub", {31'b0, if_bubble}, 32'h1);
        chk_req("f1", 1'b1, 32'h100);
        cyc(); #1;
        chk("f2_insn", Instraction_pype, 32'h13); chk("f2_bub", {31'b0, if_bubble}, 32'h1);
        chk_req("f2", 1'b1, 32'h104);
        cyc(); #1;
        chk("f3_insn", Instraction_pype, 32'h13); chk("f3_bub", {31'b0, if_bubble}, 32'h1);
        cyc(); #1; chk_ifid("f4", 32'h100, 32'h0410_2093, 1'b0);
        cyc(); #1; chk_ifid("f5", 32'h104, 32'h0420_2113, 1'b0);

        // Memory not ready for four cycles: address holds, queue drains to bubbles
        cyc(); imem.ready = 1'b0; #1;
        chk_ifid("st0", 32'h108, 32'h0430_2193, 1'b0); chk_req("st0", 1'b1, 32'h114);
        cyc(); #1;
        chk_ifid("st1", 32'h10C, 32'h0440_2213, 1'b0); chk_req("st1", 1'b1, 32'h114);
        cyc(); #1;
        chk_ifid("st2", 32'h110, 32'h0450_2293, 1'b0); chk_req("st2", 1'b1, 32'h114);
        cyc(); #1;
        chk_ifid("st3", 32'h110, 32'h13, 1'b1); chk_req("st3", 1'b1, 32'h114);
        cyc(); imem.ready = 1'b1; #1;
        chk_ifid("st4", 32'h110, 32'h13, 1'b1); chk_req("st4", 1'b1, 32'h114);
        cyc(); #1; chk_ifid("st5", 32'h110, 32'h13, 1'b1);
        cyc(); #1; chk_ifid("st6", 32'h110, 32'h13, 1'b1);
        cyc(); #1; chk_ifid("st7", 32'h114, 32'h0460_2313, 1'b0);
        cyc(); #1; chk_ifid("st8", 32'h118, 32'h0470_2393, 1'b0);

        // Reset in the middle of streaming: outputs clear without waiting for a clock
        cyc(); rst = 1'b0; #1;
        chk_ifid("mr", 32'h0, 32'h13, 1'b1); chk_req("mr", 1'b0, 32'h0);
        cyc();
        cyc(); rst = 1'b1; #1;
        chk_req("mr_rel", 1'b1, 32'h0);
        cyc(); #1; chk_ifid("mr1", 32'h0, 32'h13, 1'b1);
        cyc(); #1; chk_ifid("mr2", 32'h0, 32'h13, 1'b1);
        cyc(); #1; chk_ifid("mr3", 32'h0, 32'h0010_0093, 1'b0);
        cyc(); #1; chk_ifid("mr4", 32'h4, 32'h0020_0113, 1'b0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
